// File: rtl/inst_rom.sv
// Instruction memory for the core fetch port, with a byte-serial loader that
// holds the core in reset while a new program is streamed in.
module inst_rom #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic [31:0]           addr,
    output logic [31:0]           inst,
    input  logic                  ld_start,
    input  logic                  ld_valid,
    input  logic [7:0]            ld_byte,
    input  logic                  ld_end,
    output logic                  ld_ready,
    output logic                  ld_done,
    output logic                  ld_full,
    output logic                  cpu_hold,
    output logic [DEPTH_LOG2:0]   word_cnt
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] LAST_IDX = {DEPTH_LOG2{1'b1}};
    localparam logic [DEPTH_LOG2:0]   MAX_CNT  = (DEPTH_LOG2+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                  state_r, state_n_s;
    logic [31:0]             mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0]   wptr_r, wptr_n_s;
    logic [1:0]              bcnt_r, bcnt_n_s;
    logic [23:0]             asm_r, asm_n_s;
    logic [DEPTH_LOG2:0]     word_cnt_r, word_cnt_n_s;
    logic                    ld_full_r, ld_full_n_s;
    logic                    ld_ready_r, ld_ready_n_s;
    logic                    ld_done_r, ld_done_n_s;
    logic                    cpu_hold_r, cpu_hold_n_s;
    logic                    acc_s, we_s, last_write_s;
    logic [31:0]             wdata_s, partial_s, asm_after_s;
    logic [1:0]              cnt_after_s;
    logic                    unused_addr_s;

    // A restart in the same cycle wins over any byte offered on the load port.
    assign acc_s         = (state_r == ST_LOAD) && ld_valid && !ld_start;
    assign last_write_s  = we_s && (wptr_r == LAST_IDX);
    assign unused_addr_s = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};

    // Left-justified partial word built from bytes gathered so far, including this cycle's byte.
    always_comb begin
        cnt_after_s = acc_s ? (bcnt_r + 2'd1) : bcnt_r;
        asm_after_s = acc_s ? {asm_r, ld_byte} : {8'h00, asm_r};
        case (cnt_after_s)
            2'd1:    partial_s = {asm_after_s[7:0], 24'h000000};
            2'd2:    partial_s = {asm_after_s[15:0], 16'h0000};
            2'd3:    partial_s = {asm_after_s[23:0], 8'h00};
            default: partial_s = 32'h00000000;
        endcase
    end

    // Load datapath: byte assembly, word writes, pointers and counters.
    always_comb begin
        wptr_n_s     = wptr_r;
        bcnt_n_s     = bcnt_r;
        asm_n_s      = asm_r;
        word_cnt_n_s = word_cnt_r;
        ld_full_n_s  = ld_full_r;
        we_s         = 1'b0;
        wdata_s      = 32'h00000000;
        if (ld_start && (state_r == ST_RUN || state_r == ST_LOAD)) begin
            wptr_n_s     = '0;
            bcnt_n_s     = 2'd0;
            asm_n_s      = 24'h000000;
            word_cnt_n_s = '0;
            ld_full_n_s  = 1'b0;
        end else if (state_r == ST_LOAD) begin
            if (acc_s) begin
                asm_n_s  = {asm_r[15:0], ld_byte};
                bcnt_n_s = bcnt_r + 2'd1;
            end else begin
                asm_n_s  = asm_r;
            end
            if (acc_s && bcnt_r == 2'd3) begin
                we_s    = 1'b1;
                wdata_s = {asm_r, ld_byte};
            end else if (ld_end && cnt_after_s != 2'd0) begin
                we_s     = 1'b1;
                wdata_s  = partial_s;
                bcnt_n_s = 2'd0;
            end else begin
                we_s = 1'b0;
            end
            if (we_s) begin
                wptr_n_s = wptr_r + DEPTH_LOG2'(1);
                if (word_cnt_r != MAX_CNT) begin
                    word_cnt_n_s = word_cnt_r + (DEPTH_LOG2+1)'(1);
                end else begin
                    word_cnt_n_s = word_cnt_r;
                end
                if (wptr_r == LAST_IDX) begin
                    ld_full_n_s = 1'b1;
                end else begin
                    ld_full_n_s = ld_full_r;
                end
            end else begin
                wptr_n_s = wptr_r;
            end
        end else begin
            wptr_n_s = wptr_r;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (ld_start) state_n_s = ST_LOAD;
                else          state_n_s = ST_RUN;
            end
            ST_LOAD: begin
                if (ld_start)                     state_n_s = ST_LOAD;
                else if (ld_end || last_write_s)  state_n_s = ST_DRAIN;
                else                              state_n_s = ST_LOAD;
            end
            ST_DRAIN: state_n_s = ST_RUN;
            default:  state_n_s = ST_RUN;
        endcase
    end

    // Output decode from the next state so the registered outputs track the state register.
    always_comb begin
        ld_ready_n_s = (state_n_s == ST_LOAD);
        ld_done_n_s  = (state_n_s == ST_DRAIN);
        cpu_hold_n_s = (state_n_s != ST_RUN);
    end

    // Control and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_r     <= '0;
            bcnt_r     <= 2'd0;
            asm_r      <= 24'h000000;
            word_cnt_r <= '0;
            ld_full_r  <= 1'b0;
            ld_ready_r <= 1'b0;
            ld_done_r  <= 1'b0;
            cpu_hold_r <= 1'b0;
        end else begin
            wptr_r     <= wptr_n_s;
            bcnt_r     <= bcnt_n_s;
            asm_r      <= asm_n_s;
            word_cnt_r <= word_cnt_n_s;
            ld_full_r  <= ld_full_n_s;
            ld_ready_r <= ld_ready_n_s;
            ld_done_r  <= ld_done_n_s;
            cpu_hold_r <= cpu_hold_n_s;
        end
    end

    // Memory write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (we_s && !rst) begin
            mem_r[wptr_r] <= wdata_s;
        end
    end

    // Zero-latency fetch; a nop is returned whenever the core is not running.
    always_comb begin
        if (ce && state_r == ST_RUN) begin
            inst = mem_r[addr[DEPTH_LOG2+1:2]];
        end else begin
            inst = 32'h00000000;
        end
    end

    assign ld_ready = ld_ready_r;
    assign ld_done  = ld_done_r;
    assign ld_full  = ld_full_r;
    assign cpu_hold = cpu_hold_r;
    assign word_cnt = word_cnt_r;

endmodule

// File: tb/tb_inst_rom.sv
// Scoreboard bench for inst_rom: a byte-list reference model predicts every
// cycle's outputs; a negedge monitor pops and compares them.
module tb_inst_rom;

    localparam int DL    = 2;
    localparam int DEPTH = 1 << DL;
    localparam int M_RUN = 0, M_LOAD = 1, M_DRAIN = 2;

    logic        clk = 1'b0;
    logic        rst, ce, ld_start, ld_valid, ld_end;
    logic [31:0] addr;
    logic [7:0]  ld_byte;
    logic [31:0] inst;
    logic        ld_ready, ld_done, ld_full, cpu_hold;
    logic [DL:0] word_cnt;

    always #5 clk = ~clk;

    inst_rom #(.DEPTH_LOG2(DL)) dut (
        .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_end(ld_end),
        .ld_ready(ld_ready), .ld_done(ld_done), .ld_full(ld_full),
        .cpu_hold(cpu_hold), .word_cnt(word_cnt)
    );

    typedef struct packed {
        logic [31:0] inst;
        logic        inst_chk;
        logic        hold;
        logic        ready;
        logic        done;
        logic        full;
        logic [DL:0] wc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_err    = 0;

    // Reference model: the current load is simply the list of bytes received.
    int          phase_m = M_RUN;
    logic [7:0]  bytes_m[$];
    logic [31:0] mem_m[DEPTH];
    bit          known_m[DEPTH];
    bit          full_m = 1'b0;
    int          wc_m   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [31:0] pack_word(input int idx);
        logic [31:0] w = 32'h0;
        for (int k = 0; k < 4; k++) begin
            int p = 4 * idx + k;
            w = {w[23:0], (p < bytes_m.size()) ? bytes_m[p] : 8'h00};
        end
        return w;
    endfunction

    function automatic void commit(input int idx);
        mem_m[idx]   = pack_word(idx);
        known_m[idx] = 1'b1;
        wc_m         = idx + 1;
        if (idx == DEPTH - 1) begin
            full_m  = 1'b1;
            phase_m = M_DRAIN;
        end
    endfunction

    // Predict this cycle's outputs, then advance the model across the coming edge.
    function automatic void model_step();
        exp_t e;
        int   idx = (addr >> 2) % DEPTH;
        bit   fetch = ce && (phase_m == M_RUN);
        e.hold     = (phase_m != M_RUN);
        e.ready    = (phase_m == M_LOAD);
        e.done     = (phase_m == M_DRAIN);
        e.full     = full_m;
        e.wc       = (DL+1)'(wc_m);
        e.inst     = fetch ? mem_m[idx] : 32'h0;
        e.inst_chk = !(fetch && !known_m[idx]);
        exp_q.push_back(e);

        if (rst) begin
            phase_m = M_RUN; wc_m = 0; full_m = 1'b0; bytes_m.delete();
        end else if (phase_m == M_DRAIN) begin
            phase_m = M_RUN;
        end else if (ld_start) begin
            phase_m = M_LOAD; wc_m = 0; full_m = 1'b0; bytes_m.delete();
        end else if (phase_m == M_LOAD) begin
            if (ld_valid) begin
                bytes_m.push_back(ld_byte);
                if (bytes_m.size() % 4 == 0) commit(bytes_m.size() / 4 - 1);
            end
            if (phase_m == M_LOAD && ld_end) begin
                if (bytes_m.size() % 4 != 0) commit(bytes_m.size() / 4);
                phase_m = M_DRAIN;
            end
        end
    endfunction

    task automatic step(input bit r, input bit s, input bit v, input logic [7:0] b,
                        input bit e, input bit c, input logic [31:0] a);
        rst = r; ld_start = s; ld_valid = v; ld_byte = b; ld_end = e; ce = c; addr = a;
        model_step();
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic fetch(input logic [31:0] a);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, a);
    endtask

    task automatic send(input logic [7:0] b, input bit e, input bit c);
        step(1'b0, 1'b0, 1'b1, b, e, c, 32'h0);
    endtask

    task automatic start();
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);
    endtask

    // Monitor: one expected record per driven cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("cpu_hold", {31'h0, cpu_hold}, {31'h0, e.hold});
            check("ld_ready", {31'h0, ld_ready}, {31'h0, e.ready});
            check("ld_done",  {31'h0, ld_done},  {31'h0, e.done});
            check("ld_full",  {31'h0, ld_full},  {31'h0, e.full});
            check("word_cnt", 32'(word_cnt), 32'(e.wc));
            if (e.inst_chk) check("inst", inst, e.inst);
        end
    end

    initial begin
        logic [7:0] prog[8];
        prog = '{8'h34, 8'h02, 8'h00, 8'h01, 8'h34, 8'h03, 8'h00, 8'h02};
        for (int i = 0; i < DEPTH; i++) begin
            mem_m[i] = 32'h0; known_m[i] = 1'b0;
        end
        rst = 1'b1; ld_start = 1'b0; ld_valid = 1'b0; ld_byte = 8'h00;
        ld_end = 1'b0; ce = 1'b0; addr = 32'h0;
        @(posedge clk); #1;
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);

        // Reset state, then fetch from unloaded memory (value not checked).
        idle(3);
        fetch(32'h0);

        // Two full words, end flagged with the last byte.
        start();
        for (int i = 0; i < 8; i++) send(prog[i], i == 7, 1'b0);
        idle(2);
        fetch(32'h4); fetch(32'h0); fetch(32'h5);

        // Six bytes then a bare end: partial second word.
        start();
        for (int i = 0; i < 6; i++) send(8'(8'h11 * (i + 1)), 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0);
        idle(1);
        fetch(32'h4); fetch(32'h0);

        // Overfill: 20 bytes back to back into a 4-word memory.
        start();
        for (int i = 0; i < 20; i++) send(8'(8'h40 + i), 1'b0, 1'b0);
        idle(2);
        for (int i = 0; i < DEPTH; i++) fetch(32'(4 * i));
        fetch(32'h10);

        // Reset in the middle of the second word.
        start();
        for (int i = 0; i < 6; i++) send(8'(8'hA0 + i), 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 32'h0);
        fetch(32'h0); fetch(32'h4);

        // Restart after three bytes; fetch attempted during the load.
        start();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 8'(8'hC0 + i), 1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b1, 1'b1, 8'hEE, 1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 4; i++) send(8'(8'hD0 + i), i == 3, 1'b1);
        idle(1);
        fetch(32'h0); fetch(32'h4);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 99) < 4,
                 $urandom_range(0, 99) < 70,
                 8'($urandom),
                 $urandom_range(0, 99) < 6,
                 $urandom_range(0, 1) == 1,
                 $urandom);
        end
        idle(3);

        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
